// File: rtl/umem_pkg.sv
// Shared types for the unified memory responder.
// Optional stats outputs are enabled by UNIFIED_MEM_STATS_EN.
package umem_pkg;

    typedef enum logic [1:0] {
        UMEM_IDLE,
        UMEM_WAIT,
        UMEM_RESP
    } umem_state_t;

    localparam logic UMEM_RW_READ  = 1'b1;
    localparam logic UMEM_RW_WRITE = 1'b0;

    typedef struct packed {
        logic [31:0] addr;
        logic        rw;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        err;
    } umem_req_t;

    // Misaligned, below base, or at/after base+span bytes
    function automatic logic umem_addr_err(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [32:0] span
    );
        logic [32:0] off;
        off = {1'b0, addr} - {1'b0, base};
        return (addr[1:0] != 2'b00) || off[32] || (off >= span);
    endfunction

endpackage

// File: rtl/unified_mem_responder_if.sv
// Request/response bundle between requester and memory responder.
// Optional stats outputs are enabled by UNIFIED_MEM_STATS_EN.
interface unified_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] mem_addr;
    logic        mem_rw_mode;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_byte_en;
    logic        resp_valid;
    logic [31:0] mem_read_data;
    logic        resp_err;

    modport master (
        output req_valid,
        output mem_addr,
        output mem_rw_mode,
        output mem_write_data,
        output mem_byte_en,
        input  req_ready,
        input  resp_valid,
        input  mem_read_data,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  mem_addr,
        input  mem_rw_mode,
        input  mem_write_data,
        input  mem_byte_en,
        output req_ready,
        output resp_valid,
        output mem_read_data,
        output resp_err
    );

endinterface

// File: rtl/umem_sram_bank.sv
// Single-port word RAM with per-byte write enable and registered read.
// Optional stats outputs are enabled by UNIFIED_MEM_STATS_EN.
module umem_sram_bank #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          wr,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en && wr) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    // Read register only moves on reads, so it holds across writes
    always_ff @(posedge clk) begin
        if (en && !wr) rdata <= mem[addr];
    end

endmodule

// File: rtl/unified_mem_responder.sv
// Responder for the unified I/D memory port: FSM, wait states, checks.
// Optional stats outputs are enabled by UNIFIED_MEM_STATS_EN.
module unified_mem_responder
    import umem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_STATES = 1
) (
    input  logic clk,
    input  logic reset,
    unified_mem_responder_if.slave bus
`ifdef UNIFIED_MEM_STATS_EN
    ,
    output logic [31:0] stat_reads,
    output logic [31:0] stat_writes,
    output logic [31:0] stat_errs
`endif
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WS   = 4'(WAIT_STATES);

    umem_state_t state, state_nx;
    logic [3:0]  cnt;
    umem_req_t   req_q, req_live, req_acc;
    logic        accept, resp_entry;
    logic        rd_zero;
    logic [31:0] off;
    logic [31:0] ram_rdata;
    logic        unused_bits;

    always_comb begin
        req_live = '{
            addr:  bus.mem_addr,
            rw:    bus.mem_rw_mode,
            wdata: bus.mem_write_data,
            be:    bus.mem_byte_en,
            err:   umem_addr_err(bus.mem_addr, BASE_ADDR, SPAN)
        };
    end

    // With zero wait states the RAM access happens on the accepting edge
    assign req_acc    = (state == UMEM_IDLE) ? req_live : req_q;
    assign accept     = (state == UMEM_IDLE) && bus.req_valid;
    assign resp_entry = (state_nx == UMEM_RESP) && (state != UMEM_RESP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= UMEM_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            UMEM_IDLE: begin
                if (bus.req_valid)
                    state_nx = (WS == 4'd0) ? UMEM_RESP : UMEM_WAIT;
            end
            UMEM_WAIT: begin
                if (cnt == 4'd0) state_nx = UMEM_RESP;
            end
            UMEM_RESP: state_nx = UMEM_IDLE;
            default:   state_nx = UMEM_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready     = (state == UMEM_IDLE) && !reset;
        bus.resp_valid    = (state == UMEM_RESP);
        bus.resp_err      = (state == UMEM_RESP) && req_q.err;
        bus.mem_read_data = rd_zero ? 32'h0 : ram_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= 4'd0;
            req_q   <= '0;
            rd_zero <= 1'b1;
        end else begin
            if (accept) begin
                req_q <= req_live;
                cnt   <= (WS == 4'd0) ? 4'd0 : WS - 4'd1;
            end else if (state == UMEM_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (resp_entry && req_acc.rw == UMEM_RW_READ)
                rd_zero <= req_acc.err;
        end
    end

    assign off         = req_acc.addr - BASE_ADDR;
    assign unused_bits = ^{off[31:AW+2], off[1:0]};

    umem_sram_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_bank (
        .clk   (clk),
        .en    (resp_entry && !req_acc.err),
        .wr    (req_acc.rw == UMEM_RW_WRITE),
        .be    (req_acc.be),
        .addr  (off[AW+1:2]),
        .wdata (req_acc.wdata),
        .rdata (ram_rdata)
    );

`ifdef UNIFIED_MEM_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_reads  <= '0;
            stat_writes <= '0;
            stat_errs   <= '0;
        end else if (state == UMEM_RESP) begin
            if (req_q.err) begin
                if (stat_errs != '1) stat_errs <= stat_errs + 32'd1;
            end else if (req_q.rw == UMEM_RW_READ) begin
                if (stat_reads != '1) stat_reads <= stat_reads + 32'd1;
            end else begin
                if (stat_writes != '1) stat_writes <= stat_writes + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_unified_mem_responder.sv
// Directed bench for unified_mem_responder (WAIT_STATES=1 and 0 instances).
// Stats checks are compiled in when UNIFIED_MEM_STATS_EN is defined.
module tb_unified_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    unified_mem_responder_if bus1 ();
    unified_mem_responder_if bus0 ();

`ifdef UNIFIED_MEM_STATS_EN
    logic [31:0] s1_r, s1_w, s1_e, s0_r, s0_w, s0_e;
`endif

    unified_mem_responder #(
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'h0),
        .WAIT_STATES (1)
    ) dut1 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus1.slave)
`ifdef UNIFIED_MEM_STATS_EN
        ,
        .stat_reads  (s1_r),
        .stat_writes (s1_w),
        .stat_errs   (s1_e)
`endif
    );

    unified_mem_responder #(
        .DEPTH_WORDS (16),
        .BASE_ADDR   (32'h0),
        .WAIT_STATES (0)
    ) dut0 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus0.slave)
`ifdef UNIFIED_MEM_STATS_EN
        ,
        .stat_reads  (s0_r),
        .stat_writes (s0_w),
        .stat_errs   (s0_e)
`endif
    );

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transaction on the WAIT_STATES=1 instance
    task automatic do_txn(input string name, input logic rw,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] ed,
                          input logic ee);
        int n;
        @(negedge clk);
        bus1.req_valid      = 1'b1;
        bus1.mem_rw_mode    = rw;
        bus1.mem_addr       = addr;
        bus1.mem_write_data = wdata;
        bus1.mem_byte_en    = be;
        n = 0;
        while (!bus1.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check({name, " accept timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus1.req_valid      = 1'b0;
        bus1.mem_rw_mode    = ~rw;
        bus1.mem_addr       = 32'h0000_0003;
        bus1.mem_write_data = ~wdata;
        bus1.mem_byte_en    = 4'hF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus1.resp_valid && n < 20);
        check({name, " latency"}, 32'(n), 32'd2);
        check({name, " err"}, {31'd0, bus1.resp_err}, {31'd0, ee});
        check({name, " data"}, bus1.mem_read_data, ed);
        @(negedge clk);
        check({name, " pulse"}, {30'd0, bus1.resp_valid, bus1.req_ready},
              32'd1);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'h10,   32'hDEADBEEF, 4'b1111, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 32'h10,   32'h0,        4'b0000, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 32'h10,   32'h00AA0000, 4'b0100, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 32'h10,   32'h0,        4'b0000, 32'hDEAABEEF, 1'b0};
        vecs[4]  = '{1'b0, 32'h10,   32'hFFFFFFFF, 4'b0000, 32'hDEAABEEF, 1'b0};
        vecs[5]  = '{1'b1, 32'h10,   32'h0,        4'b0000, 32'hDEAABEEF, 1'b0};
        vecs[6]  = '{1'b1, 32'h12,   32'h0,        4'b0000, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 32'h1000, 32'h11111111, 4'b1111, 32'h0,        1'b1};
        vecs[8]  = '{1'b1, 32'h1000, 32'h0,        4'b0000, 32'h0,        1'b1};
        vecs[9]  = '{1'b1, 32'h10,   32'h0,        4'b0000, 32'hDEAABEEF, 1'b0};
        vecs[10] = '{1'b0, 32'hFFC,  32'hCAFEF00D, 4'b1111, 32'hDEAABEEF, 1'b0};
        vecs[11] = '{1'b1, 32'hFFC,  32'h0,        4'b0000, 32'hCAFEF00D, 1'b0};
        vecs[12] = '{1'b0, 32'h20,   32'h12345678, 4'b1111, 32'hCAFEF00D, 1'b0};
        vecs[13] = '{1'b1, 32'h20,   32'h0,        4'b0000, 32'h12345678, 1'b0};
        vecs[14] = '{1'b0, 32'h21,   32'h0BADF00D, 4'b1111, 32'h12345678, 1'b1};
        vecs[15] = '{1'b1, 32'h20,   32'h0,        4'b0000, 32'h12345678, 1'b0};

        bus1.req_valid = 1'b0; bus1.mem_addr = '0; bus1.mem_rw_mode = 1'b1;
        bus1.mem_write_data = '0; bus1.mem_byte_en = '0;
        bus0.req_valid = 1'b0; bus0.mem_addr = '0; bus0.mem_rw_mode = 1'b1;
        bus0.mem_write_data = '0; bus0.mem_byte_en = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst ready", {31'd0, bus1.req_ready}, 32'd0);
        check("rst resp_valid", {31'd0, bus1.resp_valid}, 32'd0);
        check("rst data", bus1.mem_read_data, 32'd0);
        check("rst err", {31'd0, bus1.resp_err}, 32'd0);
        rst = 1'b0;
        #1;
        check("post-rst ready", {31'd0, bus1.req_ready}, 32'd1);

        for (int i = 0; i < 16; i++)
            do_txn($sformatf("v%0d", i), vecs[i].rw, vecs[i].addr,
                   vecs[i].wdata, vecs[i].be, vecs[i].exp_data,
                   vecs[i].exp_err);

        // Back-to-back with req_valid held, zero wait states
        @(negedge clk);
        bus0.req_valid      = 1'b1;
        bus0.mem_rw_mode    = 1'b0;
        bus0.mem_addr       = 32'h4;
        bus0.mem_write_data = 32'h5A5A5A5A;
        bus0.mem_byte_en    = 4'hF;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("b2b ready %0d", i), {31'd0, bus0.req_ready},
                  {31'd0, (i % 2 == 0)});
            check($sformatf("b2b resp %0d", i), {31'd0, bus0.resp_valid},
                  {31'd0, (i % 2 == 1)});
            @(negedge clk);
        end
        bus0.mem_rw_mode = 1'b1;
        @(posedge clk);
        #1;
        bus0.req_valid = 1'b0;
        @(negedge clk);
        check("ws0 resp", {31'd0, bus0.resp_valid}, 32'd1);
        check("ws0 err", {31'd0, bus0.resp_err}, 32'd0);
        check("ws0 data", bus0.mem_read_data, 32'h5A5A5A5A);

        // Reset during WAIT discards the pending write
        @(negedge clk);
        bus1.req_valid      = 1'b1;
        bus1.mem_rw_mode    = 1'b0;
        bus1.mem_addr       = 32'h20;
        bus1.mem_write_data = 32'hAAAAAAAA;
        bus1.mem_byte_en    = 4'hF;
        @(posedge clk);
        #1;
        bus1.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("abort resp %0d", i), {31'd0, bus1.resp_valid},
                  32'd0);
            @(negedge clk);
        end
        rst = 1'b0;
        do_txn("abort rd", 1'b1, 32'h20, 32'h0, 4'h0, 32'h12345678, 1'b0);

`ifdef UNIFIED_MEM_STATS_EN
        do_txn("st r1", 1'b1, 32'h10, 32'h0, 4'h0, 32'hDEAABEEF, 1'b0);
        do_txn("st r2", 1'b1, 32'h20, 32'h0, 4'h0, 32'h12345678, 1'b0);
        do_txn("st w1", 1'b0, 32'h30, 32'h1, 4'hF, 32'h12345678, 1'b0);
        do_txn("st w2", 1'b0, 32'h34, 32'h2, 4'hF, 32'h12345678, 1'b0);
        do_txn("st e1", 1'b1, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1);
        check("stat_reads", s1_r, 32'd3);
        check("stat_writes", s1_w, 32'd2);
        check("stat_errs", s1_e, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
